// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/ready bus between fetch and imem
interface fetch_stage_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem handshake FSM and IF/ID pipeline register
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_en,
    input  logic [XLEN-1:0]    redirect_pc,
    fetch_stage_if.master      bus,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [XLEN-1:0]    if_id_pc_plus4,
    output logic [6:0]         opcode
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;
    state_t state, state_n;
    logic [XLEN-1:0] pc, pc_n, target, target_n, skid_pc, skid_pc_n, rpc, ld_pc;
    logic [31:0] skid_instr, skid_instr_n;
    logic ld_mem, ld_skid, flush;
    assign rpc = {redirect_pc[XLEN-1:2], 2'b00};
    assign bus.imem_req = (state == FETCH) || (state == DRAIN);
    assign bus.imem_addr = pc;
    assign opcode = if_id_instr[6:0];
    assign ld_pc = ld_mem ? pc : skid_pc;
    always_comb begin
        state_n = state;
        pc_n = pc;
        target_n = target;
        skid_pc_n = skid_pc;
        skid_instr_n = skid_instr;
        ld_mem = 1'b0;
        ld_skid = 1'b0;
        flush = 1'b0;
        case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                if (redirect_en) begin
                    flush = 1'b1;
                    if (bus.imem_ready) pc_n = rpc;
                    else begin
                        target_n = rpc;
                        state_n = DRAIN;
                    end
                end else if (bus.imem_ready && !stall) begin
                    ld_mem = 1'b1;
                    pc_n = pc + XLEN'(4);
                end else if (bus.imem_ready) begin
                    skid_pc_n = pc;
                    skid_instr_n = bus.imem_rdata;
                    pc_n = pc + XLEN'(4);
                    state_n = HOLD;
                end else flush = !stall;
            end
            HOLD: begin
                if (redirect_en) begin
                    flush = 1'b1;
                    pc_n = rpc;
                    state_n = FETCH;
                end else if (!stall) begin
                    ld_skid = 1'b1;
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                // The outstanding request must complete at the old address before retargeting
                flush = 1'b1;
                if (redirect_en) target_n = rpc;
                if (bus.imem_ready) begin
                    pc_n = redirect_en ? rpc : target;
                    state_n = FETCH;
                end
            end
            default: state_n = BOOT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
            pc <= RESET_PC;
            target <= '0;
            skid_pc <= '0;
            skid_instr <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc <= '0;
            if_id_pc_plus4 <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            target <= target_n;
            skid_pc <= skid_pc_n;
            skid_instr <= skid_instr_n;
            if (flush) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end else if (ld_mem || ld_skid) begin
                if_id_valid <= 1'b1;
                if_id_instr <= ld_mem ? bus.imem_rdata : skid_instr;
                if_id_pc <= ld_pc;
                if_id_pc_plus4 <= ld_pc + XLEN'(4);
            end
        end
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the RISC-V core.
- Holds the PC and runs a request/ready handshake to instruction memory.
- Accepts stall from the hazard logic and redirect (taken branch / jump) from execute.
- Presents the registered instruction, its PC and PC+4 to decode; `opcode` feeds control_unit directly.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into IF/ID on reset/flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold IF/ID contents; no new instruction enters decode.
- redirect_en  in  1  taken branch/jump; flush IF/ID and refetch from redirect_pc.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  fetched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  XLEN  PC of if_id_instr.
- if_id_pc_plus4  out  XLEN  if_id_pc+4, modulo 2^XLEN.
- opcode  out  7  if_id_instr[6:0], to control_unit.

Behaviour:
- Reset (synchronous, active-high; the clock and reset ports are clk and reset):
  - State=BOOT, pc=RESET_PC.
  - imem_req=0.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, opcode=7'b0010011.
  - Skid and saved-target registers cleared.
  - Reset mid-request abandons the request; imem_req drops in the cycle after reset is sampled.
- FSM states: BOOT, FETCH, HOLD, DRAIN.
- BOOT:
  - imem_req=0; always goes to FETCH next cycle.
  - redirect_en ignored.
- FETCH: imem_req=1, imem_addr=pc. Priority order:
  - redirect_en=1 and imem_ready=1: discard rdata; pc=redirect_pc; IF/ID flushed; stay FETCH.
  - redirect_en=1 and imem_ready=0: save target; IF/ID flushed; go DRAIN.
  - imem_ready=1 and stall=0: load IF/ID (valid=1, instr=rdata, pc, pc+4); pc+=4; stay FETCH.
  - imem_ready=1 and stall=1: capture rdata/pc in skid register; pc+=4; IF/ID held; go HOLD.
  - imem_ready=0: IF/ID loads bubble (valid=0, NOP_INSTR) unless stall=1, in which case IF/ID is held.
- HOLD:
  - imem_req=0.
  - stall=0: skid moves into IF/ID; go FETCH.
  - redirect_en=1 (highest priority): discard skid; IF/ID flushed; pc=redirect_pc; go FETCH.
- DRAIN:
  - imem_req=1; imem_addr stays at the old pc (once raised, a request is never withdrawn or changed).
  - imem_ready=1: discard rdata; pc=saved target; go FETCH.
  - A new redirect_en in DRAIN overwrites the saved target.
  - If redirect_en and imem_ready occur in the same cycle, the new target wins.
- Flush: if_id_valid=0, if_id_instr=NOP_INSTR. Flush overrides stall.
- Latency and throughput:
  - Zero-wait memory (ready in the same cycle as req): one instruction per cycle.
  - An instruction appears on if_id_* the cycle after its ready.
  - First valid if_id_* appears 2 cycles after reset deasserts.
- Arithmetic: pc+4 wraps at 2^XLEN (0xFFFF_FFFC → 0x0000_0000).
- opcode is always if_id_instr[6:0], including during bubbles.

Test Plan:
- Reset then zero-wait memory returning 0x00500093 at 0x0: cycle 2 shows if_id_valid=1, if_id_pc=0, pc_plus4=4, opcode=7'b0010011; addresses 0,4,8 issued on consecutive cycles.
- Memory with 2 wait cycles per request: imem_addr stable across the wait; IF/ID shows bubbles (valid=0, instr=0x00000013) between instructions.
- stall=1 asserted when ready returns instruction at 0x8: IF/ID holds the 0x4 instruction, FSM in HOLD, imem_req=0; stall drops → 0x8 instruction appears next cycle, fetch resumes at 0xC.
- redirect_en with redirect_pc=0x103 while a request is outstanding (ready low): IF/ID flushed, DRAIN keeps the old address until ready, next request goes to 0x100, returned data at the old address never reaches IF/ID.
- Second redirect to 0x200 during DRAIN, coincident with ready: next fetch goes to 0x200.
- reset pulsed during a wait state: imem_req drops, fetch restarts at RESET_PC, if_id_valid=0; pc_plus4 wrap check from 0xFFFF_FFFC gives 0x0.
